maze_game_ctrl: RTL and testbench

- Parametrised 8x8 LED-matrix maze game core: player position, wall collision, countdown timer, and win/lose state machine.
- Drives the row-scanned red/green matrix and provides BCD time digits for an external seven-segment driver.
- Maze, start/exit cells, time limit and win picture are parameters, so new levels need no RTL change.
- Sits between the keypad debounce/decode path (direction pulses) and the matrix/seg7 output pins.

---
 rtl/maze_game_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_maze_game_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/maze_game_ctrl.sv
// 8x8 maze game core: player, timer, win/lose FSM, row-scanned matrix.
// Build option MAZE_WALL_BLOCK_EN: walls block moves; 15 bumps lose.
module maze_game_ctrl #(
  parameter logic [63:0] MAP        = 64'hFB89_ADAD_ADA5_91DF,
  parameter logic [63:0] WIN_PIC    = 64'h3C42_A581_A599_423C,
  parameter int          START_ROW  = 7,
  parameter int          START_COL  = 2,
  parameter int          EXIT_ROW   = 0,
  parameter int          EXIT_COL   = 5,
  parameter int          TIME_LIMIT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       scan_tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       restart,
  output logic [7:0] disp_row,
  output logic [7:0] disp_red,
  output logic [7:0] disp_green,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic [1:0] game_state
);

  typedef enum logic [1:0] {
    PLAY = 2'b00,
    WIN  = 2'b01,
    LOSE = 2'b10
  } state_t;

  localparam logic [2:0] SR     = 3'(START_ROW);
  localparam logic [2:0] SC     = 3'(START_COL);
  localparam logic [2:0] ER     = 3'(EXIT_ROW);
  localparam logic [2:0] EC     = 3'(EXIT_COL);
  localparam logic [3:0] T_TENS = 4'(TIME_LIMIT / 10);
  localparam logic [3:0] T_ONES = 4'(TIME_LIMIT % 10);

  state_t     state, state_n;
  logic [2:0] row, col, row_n, col_n;
  logic [3:0] tens, ones, tens_n, ones_n;
  logic [2:0] cand_row, cand_col;
  logic       mv, on_grid, wall, at_exit;
  logic [2:0] scan_idx;

`ifdef MAZE_WALL_BLOCK_EN
  logic [3:0] bumps, bumps_n;
`endif

  // Highest-priority key wins even when its move falls off the grid.
  always_comb begin
    cand_row = row;
    cand_col = col;
    mv       = 1'b1;
    on_grid  = 1'b1;
    if (key_up) begin
      on_grid  = (row != 3'd0);
      cand_row = row - 3'd1;
    end else if (key_down) begin
      on_grid  = (row != 3'd7);
      cand_row = row + 3'd1;
    end else if (key_left) begin
      on_grid  = (col != 3'd0);
      cand_col = col - 3'd1;
    end else if (key_right) begin
      on_grid  = (col != 3'd7);
      cand_col = col + 3'd1;
    end else begin
      mv = 1'b0;
    end
    wall    = MAP[~{cand_row, cand_col}];
    at_exit = (cand_row == ER) && (cand_col == EC);
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    tens_n  = tens;
    ones_n  = ones;
`ifdef MAZE_WALL_BLOCK_EN
    bumps_n = bumps;
`endif
    if (restart) begin
      state_n = PLAY;
      row_n   = SR;
      col_n   = SC;
      tens_n  = T_TENS;
      ones_n  = T_ONES;
`ifdef MAZE_WALL_BLOCK_EN
      bumps_n = 4'd0;
`endif
    end else if (state == PLAY) begin
      if (sec_tick && {tens, ones} != 8'h00) begin
        if (tens == 4'd0 && ones == 4'd1)
          state_n = LOSE;
        if (ones == 4'd0) begin
          ones_n = 4'd9;
          tens_n = tens - 4'd1;
        end else begin
          ones_n = ones - 4'd1;
        end
      end
      // A winning move overrides a same-cycle expiry.
      if (mv && on_grid) begin
        if (wall) begin
`ifdef MAZE_WALL_BLOCK_EN
          if (bumps != 4'd15)
            bumps_n = bumps + 4'd1;
          if (bumps >= 4'd14)
            state_n = LOSE;
`else
          row_n   = cand_row;
          col_n   = cand_col;
          state_n = LOSE;
`endif
        end else begin
          row_n = cand_row;
          col_n = cand_col;
          if (at_exit)
            state_n = WIN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PLAY;
      row   <= SR;
      col   <= SC;
      tens  <= T_TENS;
      ones  <= T_ONES;
`ifdef MAZE_WALL_BLOCK_EN
      bumps <= 4'd0;
`endif
    end else begin
      state <= state_n;
      row   <= row_n;
      col   <= col_n;
      tens  <= tens_n;
      ones  <= ones_n;
`ifdef MAZE_WALL_BLOCK_EN
      bumps <= bumps_n;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_idx   <= 3'd0;
      disp_row   <= 8'h80;
      disp_red   <= 8'h00;
      disp_green <= 8'h00;
    end else if (scan_tick) begin
      scan_idx <= scan_idx + 3'd1;
      disp_row <= 8'h80 >> scan_idx;
      case (state)
        WIN: begin
          disp_green <= WIN_PIC[{~scan_idx, 3'b111} -: 8];
          disp_red   <= 8'h00;
        end
        LOSE: begin
          disp_green <= 8'hFF;
          disp_red   <= 8'h00;
        end
        default: begin
          disp_green <= MAP[{~scan_idx, 3'b111} -: 8];
          disp_red   <= (row == scan_idx) ? (8'h80 >> col) : 8'h00;
        end
      endcase
    end
  end

  assign time_tens  = tens;
  assign time_ones  = ones;
  assign game_state = state;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Scoreboard bench for maze_game_ctrl against a cell/seconds level model.
module tb_maze_game_ctrl;

  localparam logic [63:0] MAP     = 64'hFB89_ADAD_ADA5_91DF;
  localparam logic [63:0] WIN_PIC = 64'h3C42_A581_A599_423C;
  localparam int START_ROW = 7, START_COL = 2;
  localparam int EXIT_ROW = 0, EXIT_COL = 5;
  localparam int TIME_LIMIT = 20;

  logic clk = 1'b0;
  logic reset = 1'b0, sec_tick = 1'b0, scan_tick = 1'b0, restart = 1'b0;
  logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic [7:0] disp_row, disp_red, disp_green;
  logic [3:0] time_tens, time_ones;
  logic [1:0] game_state;

  maze_game_ctrl dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick), .scan_tick(scan_tick),
    .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .restart(restart), .disp_row(disp_row),
    .disp_red(disp_red), .disp_green(disp_green), .time_tens(time_tens),
    .time_ones(time_ones), .game_state(game_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic [3:0] tt, to;
    logic [7:0] row, red, grn;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  // model: 0 play, 1 win, 2 lose; time in whole seconds
  int m_st, m_r, m_c, m_t, m_b, m_scan;
  logic [7:0] m_row, m_red, m_grn;

  function automatic logic [7:0] rowbyte(logic [63:0] p, int r);
    return 8'(p >> (8 * (7 - r)));
  endfunction

  function automatic bit is_wall(int r, int c);
    logic [7:0] b;
    b = rowbyte(MAP, r);
    return b[7 - c];
  endfunction

  function automatic void chk(string n, logic [7:0] a, logic [7:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endfunction

  task automatic model(input bit rst_, rs_, sec_, scn_, u, d, l, r);
    int dr, dc, nr, nc;
    bit any;
    if (rst_) begin
      m_st = 0; m_r = START_ROW; m_c = START_COL; m_t = TIME_LIMIT;
      m_b = 0; m_scan = 0; m_row = 8'h80; m_red = 0; m_grn = 0;
      return;
    end
    if (scn_) begin
      m_row = 8'(1 << (7 - m_scan));
      m_red = 8'h00;
      if (m_st == 1) m_grn = rowbyte(WIN_PIC, m_scan);
      else if (m_st == 2) m_grn = 8'hFF;
      else begin
        m_grn = rowbyte(MAP, m_scan);
        if (m_r == m_scan) m_red = 8'(1 << (7 - m_c));
      end
      m_scan = (m_scan + 1) % 8;
    end
    if (rs_) begin
      m_st = 0; m_r = START_ROW; m_c = START_COL; m_t = TIME_LIMIT; m_b = 0;
    end else if (m_st == 0) begin
      dr = 0; dc = 0; any = 1;
      if (u) dr = -1;
      else if (d) dr = 1;
      else if (l) dc = -1;
      else if (r) dc = 1;
      else any = 0;
      nr = m_r + dr; nc = m_c + dc;
      if (any && nr >= 0 && nr < 8 && nc >= 0 && nc < 8) begin
        if (is_wall(nr, nc)) begin
`ifdef MAZE_WALL_BLOCK_EN
          if (m_b < 15) m_b++;
          if (m_b == 15) m_st = 2;
`else
          m_r = nr; m_c = nc; m_st = 2;
`endif
        end else begin
          m_r = nr; m_c = nc;
          if (nr == EXIT_ROW && nc == EXIT_COL) m_st = 1;
        end
      end
      if (sec_ && m_t > 0) begin
        m_t--;
        if (m_t == 0 && m_st != 1) m_st = 2;
      end
    end
  endtask

  task automatic cyc(input bit rst_, rs_, sec_, scn_, u, d, l, r);
    exp_t e;
    @(negedge clk);
    reset = rst_; restart = rs_; sec_tick = sec_; scan_tick = scn_;
    key_up = u; key_down = d; key_left = l; key_right = r;
    model(rst_, rs_, sec_, scn_, u, d, l, r);
    e.st = 2'(m_st); e.tt = 4'(m_t / 10); e.to = 4'(m_t % 10);
    e.row = m_row; e.red = m_red; e.grn = m_grn;
    sb.push_back(e);
  endtask

  task automatic idle(); cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic sec(); cyc(0, 0, 1, 0, 0, 0, 0, 0); endtask
  task automatic rst_game(); cyc(0, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic scan8(); repeat (8) cyc(0, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic mv(input int k);
    cyc(0, 0, 0, 0, k == 0, k == 1, k == 2, k == 3);
  endtask

  // direct spec checks on the edge of the most recent cyc
  task automatic peek(input string n, input logic [1:0] st,
                      input logic [3:0] tt, input logic [3:0] to);
    @(posedge clk); #2;
    chk({n, "_state"}, 8'(game_state), 8'(st));
    chk({n, "_tens"}, 8'(time_tens), 8'(tt));
    chk({n, "_ones"}, 8'(time_ones), 8'(to));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("game_state", 8'(game_state), 8'(e.st));
        chk("time_tens", 8'(time_tens), 8'(e.tt));
        chk("time_ones", 8'(time_ones), 8'(e.to));
        chk("disp_row", disp_row, e.row);
        chk("disp_red", disp_red, e.red);
        chk("disp_green", disp_green, e.grn);
      end
    end
  end

  // 0 up, 1 down, 2 left, 3 right: open route from (7,2) to (0,5)
  int path[] = '{0, 2, 0, 0, 0, 0, 0, 3, 3, 1, 1, 1, 1, 3, 1, 3, 3,
                 0, 0, 0, 0, 0, 2, 0};

  initial begin : driver
    int k, waitc;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    peek("reset", 2'b00, 4'd2, 4'd0);
    scan8();
    scan8();

    mv(2);
`ifdef MAZE_WALL_BLOCK_EN
    peek("left_wall", 2'b00, 4'd2, 4'd0);
`else
    peek("left_wall", 2'b10, 4'd2, 4'd0);
    repeat (5) sec();
    peek("lose_frozen", 2'b10, 4'd2, 4'd0);
`endif
    scan8();

    rst_game();
    sec();
    peek("tick1", 2'b00, 4'd1, 4'd9);
    repeat (18) sec();
    sec();
    peek("expire", 2'b10, 4'd0, 4'd0);
    repeat (3) sec();
    peek("hold00", 2'b10, 4'd0, 4'd0);
    scan8();

    rst_game();
    foreach (path[i]) begin
      mv(path[i]);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
    end
    peek("win", 2'b01, 4'd2, 4'd0);
    repeat (3) sec();
    scan8();
    peek("win_frozen", 2'b01, 4'd2, 4'd0);

    rst_game();
    cyc(0, 0, 0, 0, 1, 0, 1, 0);
    scan8();
    rst_game();
    peek("restart", 2'b00, 4'd2, 4'd0);
    scan8();

`ifdef MAZE_WALL_BLOCK_EN
    rst_game();
    repeat (14) mv(2);
    idle();
    peek("bump14", 2'b00, 4'd2, 4'd0);
    mv(2);
    peek("bump15", 2'b10, 4'd2, 4'd0);
    rst_game();
`endif

    repeat (3000) begin
      k = $urandom_range(0, 9);
      cyc(0, $urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 1) == 1,
          k == 0 || (k == 4 && $urandom_range(0, 1) == 1),
          k == 1 || (k == 4 && $urandom_range(0, 1) == 1),
          k == 2 || (k == 4 && $urandom_range(0, 1) == 1),
          k == 3 || (k == 4 && $urandom_range(0, 1) == 1));
    end
    idle();

    waitc = 0;
    while (sb.size() > 0 && waitc < 20) begin
      @(posedge clk);
      waitc++;
    end
    #3;
    n_chk++;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
